// File: rtl/regfile_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file scanner: default geometry of the
// MIPS32 register file and the sweep FSM state encoding.
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam int REG_N  = 32;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      DUMP_FETCH = 3'd1,
      DUMP_WAIT  = 3'd2,
      CLEAR      = 3'd3,
      FINISH     = 3'd4
   } scan_state_t;

   // True for the states in which the core must be frozen.
   function automatic logic is_busy_state(input scan_state_t s);
      logic r;
      case (s)
         DUMP_FETCH: r = 1'b1;
         DUMP_WAIT:  r = 1'b1;
         CLEAR:      r = 1'b1;
         default:    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/regfile_scanner_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// regfile_scanner_if
// Valid/ready stream carrying dumped register words.
//   dout_valid : word available           (master -> slave)
//   dout_ready : consumer accepts the word (slave -> master)
//   dout_data  : register contents         (master -> slave)
//   dout_addr  : register index            (master -> slave)
//   dout_last  : final word of the sweep   (master -> slave)
// ---------------------------------------------------------------------------
interface regfile_scanner_if #(
   parameter int AW = regfile_pkg::REG_AW,
   parameter int DW = regfile_pkg::REG_DW
);
   logic          dout_valid;
   logic          dout_ready;
   logic [DW-1:0] dout_data;
   logic [AW-1:0] dout_addr;
   logic          dout_last;

   modport master (
      output dout_valid, dout_data, dout_addr, dout_last,
      input  dout_ready
   );

   modport slave (
      input  dout_valid, dout_data, dout_addr, dout_last,
      output dout_ready
   );
endinterface

// File: rtl/regfile_port_mux.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// regfile_port_mux
// Selects who drives the register file write port and read port 1:
// the datapath (sel_cpu_i=1) or the scanner FSM (sel_cpu_i=0).
//   sel_cpu_i             : 1 = datapath passthrough
//   cpu_we3/wa3/wd3/ra1_i : datapath requests
//   fsm_we3/wa3/wd3/ra1_i : scanner requests
//   we3/wa3/wd3/ra1_o     : to the register file
// ---------------------------------------------------------------------------
module regfile_port_mux
   import regfile_pkg::*;
#(
   parameter int AW = REG_AW,
   parameter int DW = REG_DW
) (
   input  logic          sel_cpu_i,
   input  logic          cpu_we3_i,
   input  logic [AW-1:0] cpu_wa3_i,
   input  logic [DW-1:0] cpu_wd3_i,
   input  logic [AW-1:0] cpu_ra1_i,
   input  logic          fsm_we3_i,
   input  logic [AW-1:0] fsm_wa3_i,
   input  logic [DW-1:0] fsm_wd3_i,
   input  logic [AW-1:0] fsm_ra1_i,
   output logic          we3_o,
   output logic [AW-1:0] wa3_o,
   output logic [DW-1:0] wd3_o,
   output logic [AW-1:0] ra1_o
);

   // Port ownership select; the datapath write enable never reaches the
   // register file while the scanner owns the port.
   always_comb begin
      we3_o = 1'b0;
      wa3_o = {AW{1'b0}};
      wd3_o = {DW{1'b0}};
      ra1_o = {AW{1'b0}};
      if (sel_cpu_i) begin
         we3_o = cpu_we3_i;
         wa3_o = cpu_wa3_i;
         wd3_o = cpu_wd3_i;
         ra1_o = cpu_ra1_i;
      end else begin
         we3_o = fsm_we3_i;
         wa3_o = fsm_wa3_i;
         wd3_o = fsm_wd3_i;
         ra1_o = fsm_ra1_i;
      end
   end

endmodule

// File: rtl/regfile_scanner.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// regfile_scanner
// Debug initiator in front of the register file write port and read port 1.
// In IDLE the datapath signals pass straight through. A start_clear request
// writes CLEAR_VALUE into every register (one per cycle); a start_dump request
// reads every register and streams it out on the dout interface. The core is
// stalled while a sweep runs; done pulses for one cycle at the end.
//   clk, rst_n                : clock, async active-low reset
//   start_dump, start_clear   : one-cycle sweep requests (clear has priority)
//   busy, done, cpu_stall     : sweep status (cpu_stall == busy)
//   cpu_we3/wa3/wd3/ra1/rd1   : datapath side of the register file ports
//   we3/wa3/wd3/ra1/rd1       : register file side
//   dout                      : dump stream (master modport)
// ---------------------------------------------------------------------------
module regfile_scanner
   import regfile_pkg::*;
#(
   parameter int            NREGS       = REG_N,
   parameter int            AW          = REG_AW,
   parameter int            DW          = REG_DW,
   parameter logic [DW-1:0] CLEAR_VALUE = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_dump,
   input  logic          start_clear,
   output logic          busy,
   output logic          done,
   output logic          cpu_stall,
   input  logic          cpu_we3,
   input  logic [AW-1:0] cpu_wa3,
   input  logic [DW-1:0] cpu_wd3,
   input  logic [AW-1:0] cpu_ra1,
   output logic [DW-1:0] cpu_rd1,
   output logic          we3,
   output logic [AW-1:0] wa3,
   output logic [DW-1:0] wd3,
   output logic [AW-1:0] ra1,
   input  logic [DW-1:0] rd1,
   regfile_scanner_if.master dout
);

   localparam int            IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

   scan_state_t   state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          dout_valid_q, dout_valid_d;
   logic [DW-1:0] dout_data_q, dout_data_d;
   logic [AW-1:0] dout_addr_q, dout_addr_d;
   logic          dout_last_q, dout_last_d;

   logic          sel_cpu;
   logic          fsm_we3;
   logic [AW-1:0] fsm_addr;

   // The scanner addresses both ports with the sweep index.
   assign fsm_addr = AW'(idx_q);

   // Sweep FSM: next state, index counter, dump word capture and port drive.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      dout_valid_d = dout_valid_q;
      dout_data_d  = dout_data_q;
      dout_addr_d  = dout_addr_q;
      dout_last_d  = dout_last_q;
      sel_cpu      = 1'b0;
      fsm_we3      = 1'b0;
      case (state_q)
         IDLE: begin
            sel_cpu = 1'b1;
            if (start_clear) begin
               idx_d   = {IW{1'b0}};
               state_d = CLEAR;
            end else if (start_dump) begin
               idx_d   = {IW{1'b0}};
               state_d = DUMP_FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         DUMP_FETCH: begin
            // rd1 is a combinational read of ra1 = idx, captured here.
            dout_data_d  = rd1;
            dout_addr_d  = fsm_addr;
            dout_last_d  = (idx_q == LAST_IDX);
            dout_valid_d = 1'b1;
            state_d      = DUMP_WAIT;
         end
         DUMP_WAIT: begin
            if (dout_valid_q && dout.dout_ready) begin
               dout_valid_d = 1'b0;
               if (dout_last_q) begin
                  state_d = FINISH;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = DUMP_FETCH;
               end
            end else begin
               state_d = DUMP_WAIT;
            end
         end
         CLEAR: begin
            fsm_we3 = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = FINISH;
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = CLEAR;
            end
         end
         FINISH: begin
            idx_d   = {IW{1'b0}};
            state_d = IDLE;
         end
         default: begin
            idx_d        = {IW{1'b0}};
            dout_valid_d = 1'b0;
            state_d      = IDLE;
         end
      endcase
      // Status flags are registered so they line up with the state they
      // describe.
      busy_d = is_busy_state(state_d);
      done_d = (state_d == FINISH);
   end

   // State, counter and output registers; reset drops any pending word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= {IW{1'b0}};
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_data_q  <= {DW{1'b0}};
         dout_addr_q  <= {AW{1'b0}};
         dout_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         dout_valid_q <= dout_valid_d;
         dout_data_q  <= dout_data_d;
         dout_addr_q  <= dout_addr_d;
         dout_last_q  <= dout_last_d;
      end
   end

   regfile_port_mux #(
      .AW (AW),
      .DW (DW)
   ) u_port_mux (
      .sel_cpu_i (sel_cpu),
      .cpu_we3_i (cpu_we3),
      .cpu_wa3_i (cpu_wa3),
      .cpu_wd3_i (cpu_wd3),
      .cpu_ra1_i (cpu_ra1),
      .fsm_we3_i (fsm_we3),
      .fsm_wa3_i (fsm_addr),
      .fsm_wd3_i (CLEAR_VALUE),
      .fsm_ra1_i (fsm_addr),
      .we3_o     (we3),
      .wa3_o     (wa3),
      .wd3_o     (wd3),
      .ra1_o     (ra1)
   );

   assign busy            = busy_q;
   assign cpu_stall       = busy_q;
   assign done            = done_q;
   assign cpu_rd1         = rd1;
   assign dout.dout_valid = dout_valid_q;
   assign dout.dout_data  = dout_data_q;
   assign dout.dout_addr  = dout_addr_q;
   assign dout.dout_last  = dout_last_q;

endmodule

// File: tb/tb_regfile_scanner.sv
`timescale 1ns/1ps
// Scoreboard bench for regfile_scanner with a behavioural register file.
module tb_regfile_scanner;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start_dump = 1'b0, start_clear = 1'b0;
   logic        busy, done, cpu_stall;
   logic        cpu_we3 = 1'b0;
   logic [4:0]  cpu_wa3 = 5'd0, cpu_ra1 = 5'd0;
   logic [31:0] cpu_wd3 = 32'h0;
   logic [31:0] cpu_rd1;
   logic        we3;
   logic [4:0]  wa3, ra1;
   logic [31:0] wd3, rd1;

   int n_cmp = 0, n_err = 0;
   int busy_cycles = 0, done_cnt = 0, valid_cycles = 0, acc_cnt = 0, wr_cnt = 0;
   int b0, d0, a0, w0;

   typedef struct { logic [4:0] addr; logic [31:0] data; logic last; } word_t;
   typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
   word_t sb_q[$];
   wr_t   wr_q[$];

   logic [31:0] rf [0:31];

   always #5 clk = ~clk;

   regfile_scanner_if #(.AW(5), .DW(32)) dif ();

   regfile_scanner dut (
      .clk(clk), .rst_n(rst_n), .start_dump(start_dump), .start_clear(start_clear),
      .busy(busy), .done(done), .cpu_stall(cpu_stall),
      .cpu_we3(cpu_we3), .cpu_wa3(cpu_wa3), .cpu_wd3(cpu_wd3), .cpu_ra1(cpu_ra1),
      .cpu_rd1(cpu_rd1), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .rd1(rd1),
      .dout(dif)
   );

   // Register file model: r0 hardwired to zero, combinational read.
   always @(posedge clk) if (we3 && wa3 != 5'd0) rf[wa3] <= wd3;
   assign rd1 = (ra1 == 5'd0) ? 32'h0 : rf[ra1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboards whenever the DUT presents a word or a sweep write.
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy) busy_cycles++;
         if (done) done_cnt++;
         if (dif.dout_valid) valid_cycles++;
         if (dif.dout_valid && dif.dout_ready) begin
            if (sb_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_word: got addr %0d, expected no word", dif.dout_addr);
            end else begin
               word_t w;
               w = sb_q.pop_front();
               chk("dout_addr", 32'(dif.dout_addr), 32'(w.addr));
               chk("dout_data", dif.dout_data, w.data);
               chk("dout_last", 32'(dif.dout_last), 32'(w.last));
               acc_cnt++;
            end
         end
         if (we3 && (busy || done)) begin
            if (wr_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_write: got wa3 %0d, expected no write", wa3);
            end else begin
               wr_t e;
               e = wr_q.pop_front();
               chk("clear_wa3", 32'(wa3), 32'(e.addr));
               chk("clear_wd3", wd3, e.data);
               wr_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
      cpu_we3 = 1'b1; cpu_wa3 = a; cpu_wd3 = d;
      tick();
      cpu_we3 = 1'b0;
   endtask

   task automatic push_clear();
      for (int i = 0; i < 32; i++) wr_q.push_back('{addr: 5'(i), data: 32'h0});
   endtask

   task automatic push_dump(input int mode);
      for (int i = 0; i < 32; i++) begin
         logic [31:0] d;
         if (mode == 0) d = (i == 0) ? 32'h0 : 32'(i + 100);
         else d = (i == 10) ? 32'hA5A5_0010 : (i == 12) ? 32'h55 : 32'h0;
         sb_q.push_back('{addr: 5'(i), data: d, last: (i == 31)});
      end
   endtask

   task automatic wait_done(input string name, input int bound);
      int n = 0;
      @(negedge clk);
      while (!done && n < bound) begin @(negedge clk); n++; end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, bound);
      end
      tick();
   endtask

   task automatic wait_word(input logic [4:0] a, input int bound);
      int n = 0;
      @(negedge clk);
      while (!(dif.dout_valid && dif.dout_addr == a) && n < bound) begin @(negedge clk); n++; end
      if (n >= bound) begin
         n_cmp++; n_err++;
         $display("FAIL word_timeout: got no word %0d, expected it within %0d cycles", a, bound);
      end
   endtask

   task automatic snap();
      b0 = busy_cycles; d0 = done_cnt; a0 = acc_cnt; w0 = wr_cnt;
   endtask

   initial begin
      dif.dout_ready = 1'b1;
      // 1. Reset state and passthrough
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(dif.dout_valid), 32'd0);
      chk("rst_data", dif.dout_data, 32'h0);
      chk("rst_addr", 32'(dif.dout_addr), 32'd0);
      chk("rst_last", 32'(dif.dout_last), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      cpu_we3 = 1'b1; cpu_wa3 = 5'd5; cpu_wd3 = 32'hDEAD_BEEF; cpu_ra1 = 5'd5;
      #1;
      chk("pass_we3", 32'(we3), 32'd1);
      chk("pass_wa3", 32'(wa3), 32'd5);
      chk("pass_wd3", wd3, 32'hDEAD_BEEF);
      chk("pass_stall", 32'(cpu_stall), 32'd0);
      tick();
      cpu_we3 = 1'b0;
      #1 chk("pass_rd1", cpu_rd1, 32'hDEAD_BEEF);

      // 2. Clear sweep with the datapath trying to write throughout
      rf_write(5'd1, 32'd1);
      rf_write(5'd7, 32'h1234);
      snap(); push_clear();
      cpu_we3 = 1'b1; cpu_wa3 = 5'd9; cpu_wd3 = 32'hFFFF_FFFF;
      start_clear = 1'b1; tick(); start_clear = 1'b0;
      wait_done("clear", 40);
      cpu_we3 = 1'b0;
      tick(); tick();
      chk("clr_writes", 32'(wr_cnt - w0), 32'd32);
      chk("clr_busy_cycles", 32'(busy_cycles - b0), 32'd32);
      chk("clr_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("clr_wr_q_left", 32'(wr_q.size()), 32'd0);
      cpu_ra1 = 5'd1; #1 chk("clr_r1", cpu_rd1, 32'h0);
      cpu_ra1 = 5'd7; #1 chk("clr_r7", cpu_rd1, 32'h0);

      // 3. Dump with ready tied high
      for (int i = 1; i < 32; i++) rf_write(5'(i), 32'(i + 100));
      snap(); push_dump(0);
      start_dump = 1'b1; tick(); start_dump = 1'b0;
      wait_done("dump", 100);
      chk("dump_words", 32'(acc_cnt - a0), 32'd32);
      chk("dump_busy_cycles", 32'(busy_cycles - b0), 32'd64);
      chk("dump_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("dump_sb_left", 32'(sb_q.size()), 32'd0);

      // 4. Backpressure on word 3
      snap(); push_dump(0);
      start_dump = 1'b1; tick(); start_dump = 1'b0;
      wait_word(5'd2, 20);
      tick();
      dif.dout_ready = 1'b0;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(dif.dout_valid), 32'd1);
         chk("bp_addr", 32'(dif.dout_addr), 32'd3);
         chk("bp_data", dif.dout_data, 32'd103);
         @(posedge clk);
      end
      #1 dif.dout_ready = 1'b1;
      wait_done("bp", 100);
      chk("bp_words", 32'(acc_cnt - a0), 32'd32);
      chk("bp_busy_cycles", 32'(busy_cycles - b0), 32'd69);
      chk("bp_sb_left", 32'(sb_q.size()), 32'd0);

      // 5. Simultaneous starts (clear wins) and a start_dump ignored mid-sweep
      snap(); push_clear();
      start_dump = 1'b1; start_clear = 1'b1; tick();
      start_dump = 1'b0; start_clear = 1'b0;
      repeat (10) tick();
      start_dump = 1'b1; tick(); start_dump = 1'b0;
      wait_done("both", 40);
      repeat (5) tick();
      chk("both_writes", 32'(wr_cnt - w0), 32'd32);
      chk("both_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("both_no_words", 32'(acc_cnt - a0), 32'd0);
      chk("both_busy_after", 32'(busy), 32'd0);
      chk("both_valid_after", 32'(dif.dout_valid), 32'd0);

      // 6. Reset in the middle of a dump
      rf_write(5'd10, 32'hA5A5_0010);
      push_dump(1);
      start_dump = 1'b1; tick(); start_dump = 1'b0;
      wait_word(5'd9, 40);
      @(posedge clk); @(posedge clk); #1;
      chk("mid_valid", 32'(dif.dout_valid), 32'd1);
      chk("mid_addr", 32'(dif.dout_addr), 32'd10);
      chk("mid_data", dif.dout_data, 32'hA5A5_0010);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(dif.dout_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_addr", 32'(dif.dout_addr), 32'd0);
      sb_q.delete();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      cpu_we3 = 1'b1; cpu_wa3 = 5'd12; cpu_wd3 = 32'h55;
      #1;
      chk("post_we3", 32'(we3), 32'd1);
      chk("post_wa3", 32'(wa3), 32'd12);
      chk("post_wd3", wd3, 32'h55);
      tick();
      cpu_we3 = 1'b0;
      snap(); push_dump(1);
      start_dump = 1'b1; tick(); start_dump = 1'b0;
      wait_done("fresh", 100);
      chk("fresh_words", 32'(acc_cnt - a0), 32'd32);
      chk("fresh_sb_left", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish before 200000ns");
      $fatal(1);
   end

endmodule
